imm_sequencer: RTL and testbench

Sequencing controller for the immediate-extension datapath in the Lapido processor. It accepts 16-bit immediate requests from decode through a valid/ready handshake and drives the `sign_extend` unit with the matching `opcode`. It registers the 32-bit result toward the ALU operand mux. It also runs the two-beat "load 32-bit constant" sequence: the high half is taken first, the low half second, and the two halves are merged. A timeout guards an abandoned sequence.

---
 rtl/imm_pkg.sv | 20 ++
 rtl/imm_sequencer_if.sv | 22 ++
 rtl/sign_extend.sv | 19 +
 rtl/imm_sequencer.sv | 134 +++++++++++++
 tb/tb_imm_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-extension sequencer.
package imm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1,
        HOLD    = 2'd2
    } seq_state_t;

    localparam logic [1:0] IMM_SEXT = 2'b00;
    localparam logic [1:0] IMM_HI   = 2'b01;
    localparam logic [1:0] IMM_ZEXT = 2'b10;
    localparam logic [1:0] IMM_LI32 = 2'b11;

    // Second beat of a 32-bit constant: stored high half over the zero-extended low half.
    function automatic logic [31:0] merge_hi(input logic [15:0] hi, input logic [31:0] lo);
        return {hi, 16'h0000} | lo;
    endfunction

endpackage

// File: rtl/imm_sequencer_if.sv
// Request/result handshake between decode, the sequencer and the ALU operand mux.
interface imm_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_mode;
    logic [15:0] req_imm;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    modport master (
        output req_valid, req_mode, req_imm, res_ready,
        input  req_ready, res_valid, res_data
    );

    modport slave (
        input  req_valid, req_mode, req_imm, res_ready,
        output req_ready, res_valid, res_data
    );

endinterface

// File: rtl/sign_extend.sv
// Combinational 16->32 immediate extension selected by opcode.
module sign_extend
    import imm_pkg::*;
(
    input  logic [1:0]  opcode,
    input  logic [15:0] extend,
    output logic [31:0] result
);

    always_comb begin
        result = {16'h0000, extend};
        case (opcode)
            IMM_SEXT: result = {{16{extend[15]}}, extend};
            IMM_HI:   result = {extend, 16'h0000};
            default:  ;
        endcase
    end

endmodule

// File: rtl/imm_sequencer.sv
// Immediate-extension sequencer: single-beat extends and two-beat 32-bit constant loads.
//   state   | meaning
//   IDLE    | no result held, ready for a request
//   WAIT_LO | high half of a 32-bit constant stored, waiting for the low beat
//   HOLD    | result valid on res_data until taken
module imm_sequencer
#(
    parameter int LO_TIMEOUT = 15
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    imm_sequencer_if.slave    bus,
    output logic              busy,
    output logic              seq_err
);

    import imm_pkg::*;

    localparam int             CW       = $clog2(LO_TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(LO_TIMEOUT - 1);

    seq_state_t   state, state_n;
    logic [15:0]  hi_reg, hi_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]  data_q, data_n;
    logic         valid_q, valid_n;
    logic         err_q, err_n;
    logic [1:0]   ext_op;
    logic [31:0]  ext_res;
    logic         acc, take;

    always_comb begin
        bus.req_ready = 1'b0;
        if (!flush) begin
            case (state)
                IDLE, WAIT_LO: bus.req_ready = 1'b1;
                HOLD:          bus.req_ready = bus.res_ready;
                default:       bus.req_ready = 1'b0;
            endcase
        end
    end

    assign acc           = bus.req_valid & bus.req_ready;
    assign take          = valid_q & bus.res_ready;
    assign ext_op        = (state == WAIT_LO) ? IMM_ZEXT : bus.req_mode;
    assign bus.res_valid = valid_q;
    assign bus.res_data  = data_q;
    assign busy          = (state != IDLE);
    assign seq_err       = err_q;

    sign_extend u_sext (
        .opcode (ext_op),
        .extend (bus.req_imm),
        .result (ext_res)
    );

    always_comb begin
        state_n = state;
        hi_n    = hi_reg;
        cnt_n   = cnt;
        data_n  = data_q;
        valid_n = valid_q;
        err_n   = 1'b0;

        if (flush) begin
            state_n = IDLE;
            valid_n = 1'b0;
            cnt_n   = '0;
            hi_n    = '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (take) begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                    if (acc) begin
                        if (bus.req_mode == IMM_LI32) begin
                            hi_n    = bus.req_imm;
                            cnt_n   = '0;
                            valid_n = 1'b0;
                            state_n = WAIT_LO;
                        end else begin
                            data_n  = ext_res;
                            valid_n = 1'b1;
                            state_n = HOLD;
                        end
                    end
                end
                WAIT_LO: begin
                    // A low beat on the timeout cycle wins over the error.
                    if (acc) begin
                        data_n  = merge_hi(hi_reg, ext_res);
                        valid_n = 1'b1;
                        cnt_n   = '0;
                        state_n = HOLD;
                    end else if (cnt == CNT_LAST) begin
                        err_n   = 1'b1;
                        hi_n    = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n   = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            hi_reg  <= '0;
            cnt     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            hi_reg  <= hi_n;
            cnt     <= cnt_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            err_q   <= err_n;
        end
    end

endmodule

// File: tb/tb_imm_sequencer.sv
// Self-checking bench for imm_sequencer with a result scoreboard.
module tb_imm_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic busy;
    logic seq_err;

    imm_sequencer_if bus_if();

    imm_sequencer #(.LO_TIMEOUT(15)) dut (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush),
        .bus     (bus_if),
        .busy    (busy),
        .seq_err (seq_err)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_take = 0;
    int          prev_take = 0;
    logic [31:0] exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Every take is scored against the oldest expected result.
    always @(negedge clock) begin
        logic [31:0] e;
        if (reset && bus_if.res_valid && bus_if.res_ready) begin
            prev_take = last_take;
            last_take = cyc;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : ~bus_if.res_data;
            chk("sb_data", bus_if.res_data, e);
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send(input logic [1:0] m, input logic [15:0] d);
        int n;
        n = 0;
        bus_if.req_valid = 1'b1;
        bus_if.req_mode  = m;
        bus_if.req_imm   = d;
        @(negedge clock);
        while (!bus_if.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("send_ready", 32'(bus_if.req_ready), 32'd1);
        step();
        bus_if.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_mode  = 2'b00;
        bus_if.req_imm   = 16'h0000;
        bus_if.res_ready = 1'b0;

        // reset values
        @(negedge clock);
        chk("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
        chk("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
        chk("rst_res_data",  bus_if.res_data, 32'h0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_seq_err",   32'(seq_err), 32'd0);
        step();
        reset = 1'b1;
        step();

        // sign-extend, then hold with res_ready low
        exp_q.push_back(32'hFFFF8001);
        send(2'b00, 16'h8001);
        @(negedge clock);
        chk("sext_valid", 32'(bus_if.res_valid), 32'd1);
        chk("sext_data",  bus_if.res_data, 32'hFFFF8001);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clock);
            chk("hold_data",  bus_if.res_data, 32'hFFFF8001);
            chk("hold_valid", 32'(bus_if.res_valid), 32'd1);
            chk("hold_ready", 32'(bus_if.req_ready), 32'd0);
        end
        step();
        bus_if.res_ready = 1'b1;
        step();

        // back-to-back with res_ready high
        exp_q.push_back(32'h12340000);
        exp_q.push_back(32'h0000F00F);
        send(2'b01, 16'h1234);
        send(2'b10, 16'hF00F);
        step();
        @(negedge clock);
        chk("b2b_idle_valid", 32'(bus_if.res_valid), 32'd0);
        chk("b2b_gap", 32'(last_take - prev_take), 32'd1);
        step();

        // 32-bit constant with two idle cycles between beats
        send(2'b11, 16'hDEAD);
        @(negedge clock);
        chk("li_busy_hi", 32'(busy), 32'd1);
        chk("li_no_res",  32'(bus_if.res_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clock);
            chk("li_busy_wait", 32'(busy), 32'd1);
        end
        step();
        exp_q.push_back(32'hDEADBEEF);
        send(2'b00, 16'hBEEF);
        @(negedge clock);
        chk("li_busy_res", 32'(busy), 32'd1);
        chk("li_valid",    32'(bus_if.res_valid), 32'd1);
        step();

        // timeout with no low beat
        send(2'b11, 16'h1234);
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            chk("to_wait_err",  32'(seq_err), 32'd0);
            chk("to_wait_busy", 32'(busy), 32'd1);
        end
        @(negedge clock);
        chk("to_err_pulse", 32'(seq_err), 32'd1);
        chk("to_idle",      32'(busy), 32'd0);
        @(negedge clock);
        chk("to_err_end",   32'(seq_err), 32'd0);
        step();

        // low beat on the exact timeout cycle
        send(2'b11, 16'hCAFE);
        repeat (14) @(posedge clock);
        #2;
        exp_q.push_back(32'hCAFEF00D);
        send(2'b00, 16'hF00D);
        @(negedge clock);
        chk("edge_no_err", 32'(seq_err), 32'd0);
        chk("edge_valid",  32'(bus_if.res_valid), 32'd1);
        step();
        @(negedge clock);
        chk("edge_no_err_late", 32'(seq_err), 32'd0);
        step();

        // flush in WAIT_LO; concurrent request is dropped
        send(2'b11, 16'h1111);
        flush = 1'b1;
        bus_if.req_valid = 1'b1;
        bus_if.req_mode  = 2'b00;
        bus_if.req_imm   = 16'h5555;
        @(negedge clock);
        chk("flw_ready", 32'(bus_if.req_ready), 32'd0);
        step();
        flush = 1'b0;
        bus_if.req_valid = 1'b0;
        @(negedge clock);
        chk("flw_busy",  32'(busy), 32'd0);
        chk("flw_valid", 32'(bus_if.res_valid), 32'd0);
        step();
        exp_q.push_back(32'h00000ABC);
        send(2'b10, 16'h0ABC);
        step();

        // flush in HOLD drops the pending result
        bus_if.res_ready = 1'b0;
        send(2'b00, 16'h7777);
        flush = 1'b1;
        @(negedge clock);
        chk("flh_ready", 32'(bus_if.req_ready), 32'd0);
        step();
        flush = 1'b0;
        @(negedge clock);
        chk("flh_valid", 32'(bus_if.res_valid), 32'd0);
        chk("flh_busy",  32'(busy), 32'd0);
        step();
        bus_if.res_ready = 1'b1;
        exp_q.push_back(32'h0000FFFF);
        send(2'b10, 16'hFFFF);
        step();

        // asynchronous reset mid-HOLD
        bus_if.res_ready = 1'b0;
        send(2'b00, 16'h0005);
        @(negedge clock);
        chk("ar_pre_valid", 32'(bus_if.res_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid",     32'(bus_if.res_valid), 32'd0);
        chk("ar_busy",      32'(busy), 32'd0);
        chk("ar_data",      bus_if.res_data, 32'h0);
        chk("ar_req_ready", 32'(bus_if.req_ready), 32'd1);
        chk("ar_seq_err",   32'(seq_err), 32'd0);
        @(negedge clock);
        chk("ar_hold_data", bus_if.res_data, 32'h0);
        step();
        reset = 1'b1;
        bus_if.res_ready = 1'b1;
        step();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
